// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO.
// This block runs entirely in the write clock domain. It advances the binary write pointer on each
// accepted write. It publishes a registered Gray copy of that pointer for the read-domain
// synchroniser. It also derives the registered write-side status from the synchronised Gray read
// pointer: full, almost-full, fill level and a sticky overflow flag.
//
// Ports:
//   w_clk       write-domain clock
//   w_rst       synchronous active-high reset
//   w_en        write request
//   ovf_clr     clears the sticky overflow flag (a simultaneous set wins)
//   g_rptr      Gray read pointer, already synchronised into w_clk
//   w_push      write accepted this cycle (RAM write enable), combinational
//   w_addr      RAM write address
//   b_wptr      binary write pointer (MSB is the wrap bit)
//   g_wptr      registered Gray write pointer
//   full        FIFO full, registered
//   almost_full fill level >= AFULL_THRESH, registered
//   w_level     fill level 0..2^ADDR_W, registered
//   overflow    sticky: a write was attempted while full
module wptr_full_ctrl #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_en,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   g_rptr,
  output logic              w_push,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   b_wptr,
  output logic [ADDR_W:0]   g_wptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   w_level,
  output logic              overflow
);

  localparam int unsigned PtrW = ADDR_W + 1;

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
  // An XOR mask avoids a zero-width slice when ADDR_W == 1.
  localparam logic [ADDR_W:0] FullMask = PtrW'(3) << (ADDR_W - 1);
  localparam logic [ADDR_W:0] AfThresh = PtrW'(AFULL_THRESH);

  logic [ADDR_W:0] bnext;
  logic [ADDR_W:0] gnext;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] level_next;
  logic            ovf_set;

  assign w_push = w_en & ~full & ~w_rst;
  assign w_addr = b_wptr[ADDR_W-1:0];

  assign bnext = b_wptr + {{ADDR_W{1'b0}}, w_push};
  assign gnext = (bnext >> 1) ^ bnext;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= int'(ADDR_W); i++) begin
      rbin[i] = ^(g_rptr >> i);
    end
  end

  // Modulo subtraction gives the fill level across pointer wrap.
  assign level_next = bnext - rbin;
  assign ovf_set    = w_en & full;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wptr      <= bnext;
      g_wptr      <= gnext;
      full        <= (gnext == (g_rptr ^ FullMask));
      almost_full <= (level_next >= AfThresh);
      w_level     <= level_next;
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl (ADDR_W=4, AFULL_THRESH=12).
module tb_wptr_full_ctrl;

  logic       w_clk = 1'b0;
  logic       w_rst;
  logic       w_en;
  logic       ovf_clr;
  logic [4:0] g_rptr;
  logic       w_push;
  logic [3:0] w_addr;
  logic [4:0] b_wptr;
  logic [4:0] g_wptr;
  logic       full;
  logic       almost_full;
  logic [4:0] w_level;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  wptr_full_ctrl #(
    .ADDR_W      (4),
    .AFULL_THRESH(12)
  ) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_en       (w_en),
    .ovf_clr    (ovf_clr),
    .g_rptr     (g_rptr),
    .w_push     (w_push),
    .w_addr     (w_addr),
    .b_wptr     (b_wptr),
    .g_wptr     (g_wptr),
    .full       (full),
    .almost_full(almost_full),
    .w_level    (w_level),
    .overflow   (overflow)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] bm;
    logic [4:0] prev_g;
    logic       wrapped;

    w_rst = 1'b1; w_en = 1'b0; ovf_clr = 1'b0; g_rptr = '0;
    step();
    check("rst_bwptr", b_wptr, 0);
    check("rst_gwptr", g_wptr, 0);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_level", w_level, 0);
    check("rst_ovf", overflow, 0);

    // 1. Fill
    w_rst = 1'b0; w_en = 1'b1;
    #1 check("fill_push0", w_push, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check("fill_bwptr", b_wptr, k);
      check("fill_level", w_level, k);
      check("fill_afull", almost_full, (k >= 12) ? 1 : 0);
      check("fill_full", full, (k == 16) ? 1 : 0);
    end
    check("fill_gwptr", g_wptr, 5'b11000);
    check("fill_push_blocked", w_push, 0);

    // 2. Overflow: set, clear, set, then clear-with-set
    step();
    check("ovf_bwptr_hold", b_wptr, 16);
    check("ovf_set", overflow, 1);
    w_en = 1'b0; ovf_clr = 1'b1;
    step();
    check("ovf_clr", overflow, 0);
    w_en = 1'b1; ovf_clr = 1'b0;
    step();
    check("ovf_reset", overflow, 1);
    ovf_clr = 1'b1;
    step();
    check("ovf_set_wins", overflow, 1);
    check("ovf_bwptr_hold2", b_wptr, 16);
    w_en = 1'b0; ovf_clr = 1'b0;

    // 3. Drain response
    g_rptr = 5'b00110;
    #1 check("drain_full_registered", full, 1);
    step();
    check("drain_full", full, 0);
    check("drain_level12", w_level, 12);
    check("drain_afull12", almost_full, 1);
    g_rptr = 5'b00111;
    step();
    check("drain_level11", w_level, 11);
    check("drain_afull11", almost_full, 0);

    // 5. Simultaneous push and read at level 8
    g_rptr = gray(5'd8);
    step();
    check("sim_level_pre", w_level, 8);
    check("sim_addr_pre", w_addr, 0);
    w_en = 1'b1; g_rptr = gray(5'd9);
    step();
    check("sim_level", w_level, 8);
    check("sim_addr", w_addr, 1);

    // 4. Wrap with reader two entries behind
    bm = 5'd17;
    wrapped = 1'b0;
    for (int c = 0; c < 40; c++) begin
      g_rptr = gray(bm - 5'd1);
      prev_g = g_wptr;
      step();
      bm = bm + 5'd1;
      if (bm == 5'd0) begin
        wrapped = 1'b1;
        check("wrap_prev_g", prev_g, 5'b10000);
      end
      check("wrap_bwptr", b_wptr, bm);
      check("wrap_gwptr", g_wptr, gray(bm));
      check("wrap_level", w_level, 2);
      check("wrap_full", full, 0);
      check("wrap_onebit", $countones(g_wptr ^ prev_g), 1);
    end
    check("wrap_seen", wrapped, 1);

    // 6. Reset mid-operation: refill to full, raise overflow, then reset
    repeat (14) step();
    check("r6_full", full, 1);
    check("r6_level", w_level, 16);
    step();
    check("r6_ovf", overflow, 1);
    w_rst = 1'b1;
    #1 check("r6_push_in_rst", w_push, 0);
    step();
    check("r6_bwptr", b_wptr, 0);
    check("r6_gwptr", g_wptr, 0);
    check("r6_full0", full, 0);
    check("r6_afull0", almost_full, 0);
    check("r6_level0", w_level, 0);
    check("r6_ovf0", overflow, 0);
    check("r6_addr0", w_addr, 0);
    g_rptr = '0; w_rst = 1'b0;
    #1 check("r6_push_after", w_push, 1);
    check("r6_first_addr", w_addr, 0);
    step();
    check("r6_bwptr1", b_wptr, 1);
    check("r6_level1", w_level, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Parametrised write-side pointer and flag controller for the asynchronous FIFO. It runs in the write clock domain and consumes the read pointer after it has been Gray-coded and synchronised into that domain. It produces the binary write address, the Gray write pointer for the read side, and the registered write-side status: full, almost-full, fill level and sticky overflow. Compared with the basic write-pointer block, it adds generic depth, a programmable threshold, a level output and overflow reporting.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2^ADDR_W; pointers are ADDR_W+1 bits (MSB = wrap bit); legal ADDR_W >= 1
AFULL_THRESH, 12, almost_full asserts when level >= this value; legal 1..2^ADDR_W

Ports:
w_clk  in  1  write-domain clock; all state updates on rising edge
w_rst  in  1  reset, synchronous, active-high
w_en  in  1  write request
ovf_clr  in  1  clears sticky overflow
g_rptr  in  ADDR_W+1  read pointer, Gray code, already synchronised to w_clk
w_push  out  1  write accepted this cycle (RAM write enable)
w_addr  out  ADDR_W  RAM write address = b_wptr[ADDR_W-1:0]
b_wptr  out  ADDR_W+1  binary write pointer
g_wptr  out  ADDR_W+1  Gray write pointer, registered, to read-domain synchroniser
full  out  1  FIFO full, registered
almost_full  out  1  level >= AFULL_THRESH, registered
w_level  out  ADDR_W+1  write-side fill level 0..2^ADDR_W, registered
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (w_rst=1 at a rising edge): b_wptr, g_wptr, full, almost_full, w_level and overflow all go to 0.
- w_push is combinational: w_push = w_en & ~full & ~w_rst.
- w_push is the only condition that advances the pointer.
- Next pointer: bnext = b_wptr + w_push, modulo 2^(ADDR_W+1). It wraps naturally from all-ones to 0.
- Next Gray pointer: gnext = (bnext >> 1) ^ bnext.
- At each edge:
  - b_wptr <= bnext
  - g_wptr <= gnext
  - As a result, g_wptr always equals gray(b_wptr) in the same cycle.
  - g_wptr changes by exactly one bit per push and is stable otherwise.
- Full rule: full <= (gnext == {~g_rptr[ADDR_W:ADDR_W-1], g_rptr[ADDR_W-2:0]}).
  - The ADDR_W-2:0 term is empty when ADDR_W = 1.
  - full asserts on the same edge that stores the last entry. No write is accepted in the following cycle.
- Level:
  - rbin = Gray-to-binary of g_rptr, computed as an XOR prefix from the MSB down.
  - w_level <= (bnext - rbin) mod 2^(ADDR_W+1).
  - almost_full <= (bnext - rbin) >= AFULL_THRESH.
- Deassert timing: full, almost_full and w_level reflect g_rptr as sampled on the edge. Deassertion therefore follows a g_rptr change by exactly one w_clk cycle.
- Pessimism: flags may be pessimistic relative to true read progress because of synchroniser delay, which is acceptable. Optimism is not permitted.
- Simultaneous push and g_rptr advance: both are applied in the same edge's calculation, so the level is unchanged.
- Overflow:
  - Set condition: w_en & full at an edge sets overflow.
  - Clear condition: ovf_clr & ~(w_en & full) clears it.
  - Set wins over clear.
  - A rejected write never modifies the pointers.
- Reset mid-operation: the synchronous clear overrides everything, including a pending push and the overflow set. g_rptr is not reset by this block. After reset, level and flags are computed from the live g_rptr. Reset is only issued together with the read-side reset.
- No combinational path exists from g_rptr to any output except through registers.

Test Plan:
1. Fill (ADDR_W=4, AFULL_THRESH=12). Reset, g_rptr=0, then hold w_en=1.
   - almost_full=1 after the 12th push edge (w_level=12).
   - After the 16th edge: b_wptr=5'b10000, g_wptr=5'b11000, full=1, w_level=16.
   - w_push=0 from then on.
2. Overflow. At full, hold w_en=1 for 1 cycle.
   - b_wptr stays 16 and overflow=1 on the next edge.
   - Pulse ovf_clr alone: overflow=0.
   - Pulse ovf_clr together with w_en while full: overflow remains 1.
3. Drain response. From full, drive g_rptr=gray(4)=5'b00110.
   - Next edge: full=0, w_level=12, almost_full=1.
   - Then drive g_rptr=gray(5)=5'b00111: w_level=11, almost_full=0.
4. Wrap. Write continuously for 40 cycles with g_rptr tracking gray(b_wptr-2).
   - b_wptr wraps 31->0 and g_wptr goes 5'b10000->5'b00000.
   - w_level is held at 2 and full never asserts.
   - Every g_wptr change is a single-bit change; the bench checks this.
5. Simultaneous push and read. At w_level=8, push while g_rptr advances by 1 in the same cycle.
   - w_level stays 8 and w_addr increments.
6. Reset mid-operation. At full with overflow=1 and w_en=1, assert w_rst for 1 edge.
   - w_push=0 during reset.
   - All outputs are 0 after the edge; the first push after release writes w_addr=0.
